// File: rtl/sram_port_arb.sv
// Arbitrates one single-ported SRAM between a read-only fetch port and a read/write data port (optional ARB_STAT_EN adds grant/starvation counters).
// Latency: grant is combinational; read data returns RD_LAT cycles after grant, tagged to the owning port.
// Backpressure: a requester holds its request until granted; data wins unless fetch was denied STARVE_MAX cycles in a row.
module sram_port_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
`ifdef ARB_STAT_EN
    output logic [31:0]       stat_i_gnt,
    output logic [31:0]       stat_d_gnt,
    output logic [15:0]       stat_starve,
`endif
    output logic              busy
);

    typedef enum logic {PRI_D, PRI_I} arb_state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX - 1);

    arb_state_t        state, state_nxt;
    logic [2:0]        starve_cnt, starve_cnt_nxt;
    logic              force_sw;
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_own;   // 1 = fetch port, 0 = data port

    always_comb begin
        i_gnt          = 1'b0;
        d_gnt          = 1'b0;
        state_nxt      = state;
        starve_cnt_nxt = 3'd0;
        if (resetn) begin
            if (state == PRI_I) begin
                i_gnt = i_req;
                d_gnt = d_req & ~i_req;
            end else begin
                d_gnt = d_req;
                i_gnt = i_req & ~d_req;
            end
        end
        force_sw = (state == PRI_D) && i_req && !i_gnt && (starve_cnt == STARVE_LIM);
        if (force_sw)
            state_nxt = PRI_I;
        else if ((state == PRI_I) && i_gnt)
            state_nxt = PRI_D;
        if (i_req && !i_gnt)
            starve_cnt_nxt = (starve_cnt == 3'h7) ? starve_cnt : starve_cnt + 3'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= PRI_D;
            starve_cnt <= 3'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    assign sram_en    = i_gnt | d_gnt;
    assign sram_we    = d_gnt & d_we;
    assign sram_addr  = d_gnt ? d_addr : (i_gnt ? i_addr : '0);
    assign sram_wdata = d_gnt ? d_wdata : '0;

    // Tags track only reads so writes never raise rvalid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_vld <= '0;
            tag_own <= '0;
        end else begin
            for (int k = RD_LAT - 1; k > 0; k--) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_own[k] <= tag_own[k-1];
            end
            tag_vld[0] <= sram_en & ~sram_we;
            tag_own[0] <= i_gnt;
        end
    end

    assign i_rvalid = tag_vld[RD_LAT-1] & tag_own[RD_LAT-1];
    assign d_rvalid = tag_vld[RD_LAT-1] & ~tag_own[RD_LAT-1];
    assign i_rdata  = i_rvalid ? sram_rdata : '0;
    assign d_rdata  = d_rvalid ? sram_rdata : '0;
    assign busy     = |tag_vld;

`ifdef ARB_STAT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_i_gnt  <= '0;
            stat_d_gnt  <= '0;
            stat_starve <= '0;
        end else begin
            if (i_gnt && (stat_i_gnt != '1))
                stat_i_gnt <= stat_i_gnt + 32'd1;
            if (d_gnt && (stat_d_gnt != '1))
                stat_d_gnt <= stat_d_gnt + 32'd1;
            if (force_sw && (stat_starve != '1))
                stat_starve <= stat_starve + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_arb.sv
// Scoreboard bench for sram_port_arb: directed scenarios followed by random fetch/data traffic against a reference model.
module tb_sram_port_arb;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_gnt, d_gnt, i_rvalid, d_rvalid;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          sram_en, sram_we, busy;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;
`ifdef ARB_STAT_EN
    logic [31:0]   stat_i_gnt, stat_d_gnt;
    logic [15:0]   stat_starve;
`endif

    always #5 clk = ~clk;

    sram_port_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
`ifdef ARB_STAT_EN
        .stat_i_gnt(stat_i_gnt), .stat_d_gnt(stat_d_gnt), .stat_starve(stat_starve),
`endif
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a * 32'h9e3779b1) ^ 32'h1234_5678;
    endfunction

    // Physical SRAM: write-first, read data appears RD_LAT cycles after the access.
    logic [DW-1:0] sram_mem [logic [AW-1:0]];
    logic [DW-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        for (int k = RD_LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
        if (sram_en && sram_we) begin
            sram_mem[sram_addr] = sram_wdata;
            rd_pipe[0] <= '0;
        end else if (sram_en)
            rd_pipe[0] <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : init_val(sram_addr);
        else
            rd_pipe[0] <= '0;
    end
    assign sram_rdata = rd_pipe[RD_LAT-1];

    // Reference model: memory image, fetch denial streak, in-flight read times, expected responses.
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] exp_i [$];
    logic [DW-1:0] exp_d [$];
    int            rd_times [$];
    int            cyc = 0;
    int            streak = 0;
    int            n_i = 0, n_d = 0, n_sw = 0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    always @(negedge clk) begin
        logic eig, edg, ebusy;
        cyc++;
        if (!resetn) begin
            streak = 0;
            n_i = 0; n_d = 0; n_sw = 0;
            exp_i.delete(); exp_d.delete(); rd_times.delete();
            chk("reset_outputs", {58'd0, i_gnt, d_gnt, sram_en, i_rvalid, d_rvalid, busy}, 64'd0);
        end else begin
            eig = i_req && (!d_req || streak >= STARVE_MAX);
            edg = d_req && !eig;
            while (rd_times.size() > 0 && cyc - rd_times[0] > RD_LAT) void'(rd_times.pop_front());
            ebusy = rd_times.size() > 0;
            chk("i_gnt", i_gnt, eig);
            chk("d_gnt", d_gnt, edg);
            chk("sram_en", sram_en, eig | edg);
            chk("sram_we", sram_we, edg & d_we);
            chk("busy", busy, ebusy);
            if (edg) begin
                chk("sram_addr_d", sram_addr, d_addr);
                if (d_we) chk("sram_wdata", sram_wdata, d_wdata);
            end else if (eig)
                chk("sram_addr_i", sram_addr, i_addr);
            else
                chk("sram_idle_bus", {sram_addr, sram_wdata}, 64'd0);
            if (eig) begin
                exp_i.push_back(ref_rd(i_addr));
                rd_times.push_back(cyc);
                streak = 0;
                n_i++;
            end else if (i_req) begin
                streak++;
                if (streak == STARVE_MAX) n_sw++;
            end else
                streak = 0;
            if (edg) begin
                n_d++;
                if (d_we) ref_mem[d_addr] = d_wdata;
                else begin
                    exp_d.push_back(ref_rd(d_addr));
                    rd_times.push_back(cyc);
                end
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (i_rvalid && d_rvalid) chk("both_rvalid", 1'b1, 1'b0);
        if (i_rvalid) begin
            if (exp_i.size() == 0) chk("i_rvalid_unexpected", 1'b1, 1'b0);
            else chk("i_rdata", i_rdata, exp_i.pop_front());
            chk("d_rdata_quiet", d_rdata, 0);
        end
        if (d_rvalid) begin
            if (exp_d.size() == 0) chk("d_rvalid_unexpected", 1'b1, 1'b0);
            else chk("d_rdata", d_rdata, exp_d.pop_front());
            chk("i_rdata_quiet", i_rdata, 0);
        end
    end

    logic gi, gd;
    task automatic cycle();
        @(negedge clk);
        gi = i_gnt;
        gd = d_gnt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) cycle();
        resetn = 1'b1;
        cycle();

        // Single fetch
        i_req = 1; i_addr = 32'h1c00_0000;
        cycle();
        i_req = 0;
        repeat (RD_LAT + 1) cycle();

        // Contention: data first, fetch next
        i_req = 1; i_addr = 32'h1c00_0004;
        d_req = 1; d_we = 0; d_addr = 32'h0000_1000;
        cycle();
        if (gd) d_req = 0;
        cycle();
        if (gi) i_req = 0;
        repeat (RD_LAT + 1) cycle();

        // Starvation: continuous data reads against a held fetch
        i_req = 1; i_addr = 32'h1c00_0008; d_req = 1; d_we = 0;
        for (int k = 0; k < 10; k++) begin
            d_addr = 32'h100 + 32'(k * 4);
            cycle();
            if (gi) i_req = 0;
        end
        d_req = 0; i_req = 0;
        repeat (RD_LAT + 1) cycle();

        // Write then read same address
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hdead_beef;
        cycle();
        d_we = 0;
        cycle();
        d_req = 0;
        repeat (RD_LAT + 1) cycle();

        // Reset with a fetch in flight
        i_req = 1; i_addr = 32'h1c00_000c;
        cycle();
        i_req = 0;
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        repeat (RD_LAT + 2) cycle();

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            if (!i_req || gi) begin
                i_req  = ($urandom_range(0, 9) < 6);
                i_addr = 32'($urandom_range(0, 31)) * 4;
            end
            if (!d_req || gd) begin
                d_req   = ($urandom_range(0, 9) < 5);
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = 32'($urandom_range(0, 31)) * 4;
                d_wdata = $urandom;
            end
            cycle();
        end
        for (int n = 0; n < 50 && (i_req || d_req); n++) begin
            if (gi) i_req = 0;
            if (gd) d_req = 0;
            if (i_req || d_req) cycle();
        end
        if (i_req || d_req) chk("drain_timeout", 1'b1, 1'b0);
        i_req = 0; d_req = 0;
        repeat (RD_LAT + 2) cycle();
        chk("exp_i_empty", exp_i.size(), 0);
        chk("exp_d_empty", exp_d.size(), 0);
`ifdef ARB_STAT_EN
        chk("stat_i_gnt", stat_i_gnt, n_i);
        chk("stat_d_gnt", stat_d_gnt, n_d);
        chk("stat_starve", stat_starve, n_sw);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
